// File: rtl/dpb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpb_pkg
// Brief    : Shared types, sizes and the payload-length helper for the DPB
//            port-B read master.
// Revision : 1.0 - initial release
// ============================================================================
package dpb_pkg;

    localparam int DPB_WORD_BYTES = 16;
    localparam int DPB_RANK_W     = 4;
    localparam int DPB_IDX_W      = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } dpb_state_e;

    // A byte count of zero in the last word means the word is full.
    function automatic logic [10:0] dpb_byte_len(input logic [6:0] cnt,
                                                 input logic [5:0] bytecnt);
        logic [5:0] last_bytes;
        last_bytes = (bytecnt == 6'd0) ? 6'(DPB_WORD_BYTES) : bytecnt;
        return {cnt - 7'd1, 4'd0} + {5'd0, last_bytes};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpb_rd_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dpb_rd_byte_serializer
// Brief    : One-word holding register feeding a 128-bit MSB-first byte
//            shifter with valid/ready handshake towards the UDP sink.
// Revision : 1.0 - initial release
// ============================================================================
module dpb_rd_byte_serializer
    import dpb_pkg::*;
(
    input  logic                          i_pclk,
    input  logic                          i_rst_n,
    input  logic                          i_load,
    input  logic [DPB_WORD_BYTES*8-1:0]   i_load_data,
    input  logic [4:0]                    i_load_nbytes,
    input  logic                          i_load_last,
    output logic                          o_hold_free,
    output logic                          o_udp_de,
    output logic [7:0]                    o_udp_data,
    output logic                          o_udp_last,
    input  logic                          i_udp_ready
);

    logic [DPB_WORD_BYTES*8-1:0] r_hold;
    logic [4:0]                  r_hold_nb;
    logic                        r_hold_last;
    logic                        r_hold_vld;
    logic [DPB_WORD_BYTES*8-1:0] r_shift;
    logic [4:0]                  r_rem;
    logic                        r_sh_last;
    logic                        r_de;
    logic                        w_xfer;
    logic                        w_drain;

    assign w_xfer      = r_de && i_udp_ready;
    // Shifter is free this edge: idle, or its final byte is leaving now.
    assign w_drain     = !r_de || (w_xfer && (r_rem == 5'd1));
    assign o_hold_free = !r_hold_vld;
    assign o_udp_de    = r_de;
    assign o_udp_data  = r_shift[DPB_WORD_BYTES*8-1 -: 8];
    assign o_udp_last  = r_de && r_sh_last && (r_rem == 5'd1);

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_nb   <= 5'd0;
            r_hold_last <= 1'b0;
            r_hold_vld  <= 1'b0;
        end else if (i_load) begin
            r_hold      <= i_load_data;
            r_hold_nb   <= i_load_nbytes;
            r_hold_last <= i_load_last;
            r_hold_vld  <= 1'b1;
        end else if (w_drain) begin
            r_hold_vld  <= 1'b0;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_rem     <= 5'd0;
            r_sh_last <= 1'b0;
            r_de      <= 1'b0;
        end else if (w_drain && r_hold_vld) begin
            r_shift   <= r_hold;
            r_rem     <= r_hold_nb;
            r_sh_last <= r_hold_last;
            r_de      <= 1'b1;
        end else if (w_xfer) begin
            r_shift   <= r_shift << 8;
            r_rem     <= r_rem - 5'd1;
            if (r_rem == 5'd1) begin
                r_de  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpb_master_rd.sv
`default_nettype none
// ============================================================================
// Module   : dpb_master_rd
// Brief    : Reads one buffered UDP payload from BRAM port B and streams it
//            as bytes; DPB_MASTER_RD_CSUM_EN adds a 16-bit payload checksum.
// Revision : 1.0 - initial release
// ============================================================================
module dpb_master_rd
    import dpb_pkg::*;
#(
    parameter int unsigned UDP_FRAME_MAX_SIZE_128 = 7'd91,
    parameter int          RD_LATENCY             = 2
)(
    input  logic                              i_pclk,
    input  logic                              i_rst_n,
    input  logic                              i_rd_req,
    input  logic [DPB_RANK_W-1:0]             i_buf_rank,
    input  logic [DPB_IDX_W-1:0]              i_buf_128cnt,
    input  logic [5:0]                        i_buf_Bytecnt,
    input  logic                              i_frame_down,
    output logic [DPB_RANK_W+DPB_IDX_W-1:0]   o_dpb_rd_b_addr,
    input  logic [DPB_WORD_BYTES*8-1:0]       i_dpb_rd_b_rd_data,
    output logic                              o_dpb_rd_b_clk,
    output logic                              o_dpb_rd_b_cea,
    output logic                              o_dpb_rd_b_ocea,
    output logic                              o_dpb_rd_b_rst_n,
    output logic                              o_udp_de,
    output logic [7:0]                        o_udp_data,
    output logic                              o_udp_last,
    input  logic                              i_udp_ready,
    output logic                              o_busy,
    output logic                              o_rd_down,
    output logic                              o_frame_last,
    output logic [10:0]                       o_byte_len,
`ifdef DPB_MASTER_RD_CSUM_EN
    output logic [15:0]                       o_payload_csum,
`endif
    output logic                              error
);

    localparam logic [7:0] c_MAX_WORDS = 8'(UDP_FRAME_MAX_SIZE_128);
    localparam logic [2:0] c_PEND_INIT = 3'(RD_LATENCY + 1);

    dpb_state_e             r_state;
    dpb_state_e             w_state_nxt;
    logic [DPB_RANK_W-1:0]  r_rank;
    logic [DPB_IDX_W-1:0]   r_cnt;
    logic [5:0]             r_bytecnt;
    logic [DPB_IDX_W-1:0]   r_idx;
    logic [DPB_RANK_W+DPB_IDX_W-1:0] r_addr;
    logic                   r_cea;
    logic                   r_rd_out;
    logic [2:0]             r_pend;
    logic [10:0]            r_byte_len;
    logic                   r_frame_last;
    logic                   r_error;
    logic                   w_req_ok;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_hold_free;
    logic                   w_capture;
    logic                   w_more;
    logic                   w_issue_next;
    logic [4:0]             w_last_nb;
    logic [4:0]             w_cap_nb;
    logic                   w_final_xfer;

    assign w_req_ok     = (i_buf_128cnt != 7'd0) && ({1'b0, i_buf_128cnt} <= c_MAX_WORDS);
    assign w_accept     = i_rd_req && (r_state == S_IDLE) && w_req_ok;
    assign w_reject     = i_rd_req && !w_accept;
    // Only one read is ever outstanding; its data stays on the BRAM output
    // register until the next read, so it may wait for the holding register.
    assign w_capture    = r_rd_out && (r_pend == 3'd1) && w_hold_free;
    assign w_more       = (r_idx != (r_cnt - 7'd1));
    assign w_issue_next = w_capture && w_more;
    assign w_last_nb    = ((r_bytecnt == 6'd0) || (r_bytecnt > 6'd16)) ? 5'd16 : r_bytecnt[4:0];
    assign w_cap_nb     = w_more ? 5'd16 : w_last_nb;
    assign w_final_xfer = o_udp_de && i_udp_ready && o_udp_last;

    assign o_dpb_rd_b_clk   = i_pclk;
    assign o_dpb_rd_b_ocea  = 1'b1;
    assign o_dpb_rd_b_rst_n = 1'b1;
    assign o_dpb_rd_b_addr  = r_addr;
    assign o_dpb_rd_b_cea   = r_cea;
    assign o_byte_len       = r_byte_len;
    assign o_frame_last     = r_frame_last;
    assign error            = r_error;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != S_IDLE);
        o_rd_down   = (r_state == S_DONE);
        case (r_state)
            S_IDLE:   if (w_accept)     w_state_nxt = S_FETCH;
            S_FETCH:                    w_state_nxt = S_WAIT;
            S_WAIT:   if (w_capture)    w_state_nxt = S_STREAM;
            S_STREAM: if (w_final_xfer) w_state_nxt = S_DONE;
            S_DONE:                     w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rank       <= '0;
            r_cnt        <= '0;
            r_bytecnt    <= 6'd0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_cea        <= 1'b0;
            r_rd_out     <= 1'b0;
            r_pend       <= 3'd0;
            r_byte_len   <= 11'd0;
            r_frame_last <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_cea <= w_accept || w_issue_next;
            if (w_reject) begin
                r_error <= 1'b1;
            end
            if (w_accept) begin
                r_rank       <= i_buf_rank;
                r_cnt        <= i_buf_128cnt;
                r_bytecnt    <= i_buf_Bytecnt;
                r_frame_last <= i_frame_down;
                r_byte_len   <= dpb_byte_len(i_buf_128cnt, i_buf_Bytecnt);
                r_idx        <= '0;
                r_addr       <= {i_buf_rank, 7'd0};
                r_rd_out     <= 1'b1;
                r_pend       <= c_PEND_INIT;
            end else if (w_issue_next) begin
                r_idx        <= r_idx + 7'd1;
                r_addr       <= {r_rank, r_idx + 7'd1};
                r_pend       <= c_PEND_INIT;
            end else if (w_capture) begin
                r_rd_out     <= 1'b0;
            end else if (r_rd_out && (r_pend > 3'd1)) begin
                r_pend       <= r_pend - 3'd1;
            end
        end
    end

    dpb_rd_byte_serializer u_ser (
        .i_pclk        (i_pclk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_capture),
        .i_load_data   (i_dpb_rd_b_rd_data),
        .i_load_nbytes (w_cap_nb),
        .i_load_last   (!w_more),
        .o_hold_free   (w_hold_free),
        .o_udp_de      (o_udp_de),
        .o_udp_data    (o_udp_data),
        .o_udp_last    (o_udp_last),
        .i_udp_ready   (i_udp_ready)
    );

`ifdef DPB_MASTER_RD_CSUM_EN
    logic [15:0] r_csum;
    logic        r_csum_lo;
    logic [15:0] w_csum_add;
    logic [16:0] w_csum_raw;

    // Even byte positions are the high half of each big-endian 16-bit word.
    assign w_csum_add     = r_csum_lo ? {8'd0, o_udp_data} : {o_udp_data, 8'd0};
    assign w_csum_raw     = {1'b0, r_csum} + {1'b0, w_csum_add};
    assign o_payload_csum = r_csum;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum    <= 16'd0;
            r_csum_lo <= 1'b0;
        end else if (w_accept) begin
            r_csum    <= 16'd0;
            r_csum_lo <= 1'b0;
        end else if (o_udp_de && i_udp_ready) begin
            r_csum    <= w_csum_raw[15:0] + {15'd0, w_csum_raw[16]};
            r_csum_lo <= !r_csum_lo;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpb_master_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpb_master_rd
// Brief    : Randomized scoreboard bench for dpb_master_rd with a BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dpb_master_rd;

    localparam int RD_LAT = 2;

    logic         pclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req = 1'b0;
    logic [3:0]   buf_rank = 4'd0;
    logic [6:0]   buf_cnt = 7'd0;
    logic [5:0]   buf_bcnt = 6'd0;
    logic         frame_down = 1'b0;
    logic [10:0]  b_addr;
    logic [127:0] b_rd_data;
    logic         b_clk, b_cea, b_ocea, b_rst_n;
    logic         udp_de, udp_last, udp_ready = 1'b1;
    logic [7:0]   udp_data;
    logic         busy, rd_down, frame_last, err;
    logic [10:0]  byte_len;
`ifdef DPB_MASTER_RD_CSUM_EN
    logic [15:0]  payload_csum;
`endif

    dpb_master_rd #(.UDP_FRAME_MAX_SIZE_128(7'd91), .RD_LATENCY(RD_LAT)) dut (
        .i_pclk(pclk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_buf_rank(buf_rank),
        .i_buf_128cnt(buf_cnt), .i_buf_Bytecnt(buf_bcnt), .i_frame_down(frame_down),
        .o_dpb_rd_b_addr(b_addr), .i_dpb_rd_b_rd_data(b_rd_data), .o_dpb_rd_b_clk(b_clk),
        .o_dpb_rd_b_cea(b_cea), .o_dpb_rd_b_ocea(b_ocea), .o_dpb_rd_b_rst_n(b_rst_n),
        .o_udp_de(udp_de), .o_udp_data(udp_data), .o_udp_last(udp_last),
        .i_udp_ready(udp_ready), .o_busy(busy), .o_rd_down(rd_down),
        .o_frame_last(frame_last), .o_byte_len(byte_len),
`ifdef DPB_MASTER_RD_CSUM_EN
        .o_payload_csum(payload_csum),
`endif
        .error(err)
    );

    always #5 pclk = ~pclk;

    // BRAM port B: address sampled when cea is high, output held otherwise.
    logic [127:0] mem [0:2047];
    logic [127:0] pipe [0:2];
    always @(posedge pclk) begin
        if (b_cea) pipe[0] <= mem[b_addr];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign b_rd_data = pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard state for the single outstanding transfer
    logic [8:0]  exp_bytes [$];
    logic [10:0] exp_addr [$];
    int          exp_len;
    logic [15:0] exp_csum;
    bit          xfer_active = 0;
    bit          first_pending = 0;
    bit          gap_seen = 0;
    int          bytes_done = 0;
    int          req_edge = 0;
    int          last_xfer_cyc = 0;
    int          ready_mode = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data;
    logic        prev_last;

    initial begin
        int ph = 0;
        forever begin
            @(posedge pclk); #1;
            case (ready_mode)
                0: udp_ready = 1'b1;
                1: begin udp_ready = ((ph / 3) % 2) == 0; ph++; end
                default: udp_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    always @(negedge pclk) begin
        logic [10:0] ea;
        logic [8:0]  eb;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (b_cea) begin
                if (exp_addr.size() == 0) chk(1'b0, "addr_unexpected", b_addr, 0);
                else begin ea = exp_addr.pop_front(); chk(b_addr == ea, "bram_addr", b_addr, ea); end
            end
            if (prev_stall)
                chk(udp_de && udp_data == prev_data && udp_last == prev_last, "hold_stable",
                    {udp_de, udp_last, udp_data}, {1'b1, prev_last, prev_data});
            if (xfer_active && first_pending && udp_de) begin
                chk(cyc == req_edge + RD_LAT + 2, "first_byte_latency", cyc, req_edge + RD_LAT + 2);
                first_pending = 0;
            end
            if (xfer_active && !first_pending && !udp_de && exp_bytes.size() > 0 && ready_mode == 0)
                gap_seen = 1;
            if (udp_de && udp_ready) begin
                if (exp_bytes.size() == 0) chk(1'b0, "byte_unexpected", udp_data, 0);
                else begin
                    eb = exp_bytes.pop_front();
                    chk({udp_last, udp_data} == eb, "udp_byte", {udp_last, udp_data}, eb);
                end
                bytes_done++;
                last_xfer_cyc = cyc;
            end
            if (rd_down) begin
                if (!xfer_active) chk(1'b0, "rd_down_unexpected", 1, 0);
                else begin
                    chk(exp_bytes.size() == 0, "bytes_left_at_done", exp_bytes.size(), 0);
                    chk(cyc == last_xfer_cyc + 1, "rd_down_timing", cyc, last_xfer_cyc + 1);
                    chk(byte_len == 11'(exp_len), "byte_len_at_done", byte_len, exp_len);
                    if (ready_mode == 0) chk(!gap_seen, "gap_free", gap_seen, 0);
`ifdef DPB_MASTER_RD_CSUM_EN
                    chk(payload_csum == exp_csum, "payload_csum", payload_csum, exp_csum);
`endif
                    xfer_active = 0;
                end
            end
            prev_stall = udp_de && !udp_ready;
            prev_data  = udp_data;
            prev_last  = udp_last;
        end
    end

    task automatic do_req(input logic [3:0] rk, input logic [6:0] cn, input logic [5:0] bc,
                          input logic fd, input int mode);
        int nb;
        int total;
        logic [127:0] w;
        logic [7:0] bv;
        logic [31:0] s;
        @(posedge pclk); #1;
        ready_mode = mode;
        exp_bytes.delete();
        exp_addr.delete();
        total = 0;
        s = 0;
        for (int wi = 0; wi < int'(cn); wi++) begin
            exp_addr.push_back({rk, 7'(wi)});
            w = mem[{rk, 7'(wi)}];
            nb = (wi == int'(cn) - 1) ? ((bc == 0) ? 16 : int'(bc)) : 16;
            for (int b = 0; b < nb; b++) begin
                bv = w[127 - 8*b -: 8];
                exp_bytes.push_back({(wi == int'(cn) - 1) && (b == nb - 1), bv});
                s += (total % 2 == 0) ? 32'({bv, 8'h00}) : 32'(bv);
                total++;
            end
        end
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        exp_len = total;
        exp_csum = s[15:0];
        first_pending = 1; gap_seen = 0; bytes_done = 0; xfer_active = 1;
        req_edge = cyc + 1;
        rd_req = 1'b1; buf_rank = rk; buf_cnt = cn; buf_bcnt = bc; frame_down = fd;
        @(posedge pclk); #1;
        rd_req = 1'b0;
        chk(busy == 1'b1, "busy_after_accept", busy, 1);
        chk(byte_len == 11'(exp_len), "byte_len_after_accept", byte_len, exp_len);
        chk(frame_last == fd, "frame_last_latched", frame_last, fd);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (xfer_active && n < bound) begin @(negedge pclk); #1; n++; end
        if (xfer_active) begin
            chk(1'b0, "done_timeout", n, bound);
            xfer_active = 0; exp_bytes.delete(); exp_addr.delete();
        end else begin
            @(negedge pclk); #1;
            chk(!busy && !rd_down, "idle_after_done", {busy, rd_down}, 0);
        end
    endtask

    task automatic pulse_raw(input logic [3:0] rk, input logic [6:0] cn);
        @(posedge pclk); #1;
        rd_req = 1'b1; buf_rank = rk; buf_cnt = cn; buf_bcnt = 6'd0;
        @(posedge pclk); #1;
        rd_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge pclk); #2;
        rst_n = 1'b0;
        xfer_active = 0; exp_bytes.delete(); exp_addr.delete();
        repeat (3) @(negedge pclk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        for (int a = 0; a < 2048; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = 128'h0102030405060708090a0b0c0d0e0f10;
        mem[{4'd5, 7'd0}] = {32'h4500001C, 96'd0};
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;

        // Reset values
        #12;
        chk(udp_de == 0 && udp_last == 0, "rst_udp_de_last", {udp_de, udp_last}, 0);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(rd_down == 0, "rst_rd_down", rd_down, 0);
        chk(frame_last == 0, "rst_frame_last", frame_last, 0);
        chk(udp_data == 0, "rst_udp_data", udp_data, 0);
        chk(byte_len == 0, "rst_byte_len", byte_len, 0);
        chk(b_addr == 0 && b_cea == 0, "rst_addr_cea", {b_addr, b_cea}, 0);
        chk(err == 0, "rst_error", err, 0);
        chk(b_ocea == 1 && b_rst_n == 1, "bram_static_ctrl", {b_ocea, b_rst_n}, 2'b11);
        chk(b_clk == pclk, "bram_clk", b_clk, pclk);
        @(negedge pclk); #3 rst_n = 1'b1;

        // Oversized and empty requests are rejected
        pulse_raw(4'd2, 7'd92);
        chk(err == 1 && busy == 0, "reject_cnt92", {err, busy}, 2'b10);
        repeat (4) @(negedge pclk);
        chk(busy == 0, "reject_cnt92_stays_idle", busy, 0);
        apply_reset();
        chk(err == 0, "error_cleared_by_reset", err, 0);
        pulse_raw(4'd2, 7'd0);
        chk(err == 1 && busy == 0, "reject_cnt0", {err, busy}, 2'b10);
        apply_reset();

        // Two full words from rank 3
        do_req(4'd3, 7'd2, 6'd0, 1'b1, 0);
        wait_done(500);
        chk(err == 0, "no_error_normal", err, 0);

        // Single word, 5 valid bytes
        do_req(4'd0, 7'd1, 6'd5, 1'b0, 0);
        wait_done(500);

        // Maximum size with ready toggling every 3 cycles
        do_req(4'($urandom_range(15)), 7'd91, 6'd0, 1'b0, 1);
        wait_done(8000);

        // Request while busy is rejected, transfer continues
        do_req(4'd1, 7'd4, 6'd7, 1'b0, 0);
        repeat (3) @(posedge pclk);
        pulse_raw(4'd2, 7'd3);
        chk(err == 1 && busy == 1, "reject_while_busy", {err, busy}, 2'b11);
        wait_done(1000);

        // Request coinciding with the done pulse
        apply_reset();
        do_req(4'd4, 7'd1, 6'd3, 1'b0, 0);
        lim = 0;
        while (xfer_active && lim < 500) begin @(negedge pclk); #1; lim++; end
        chk(rd_down == 1, "in_done_cycle", rd_down, 1);
        rd_req = 1'b1; buf_rank = 4'd4; buf_cnt = 7'd1; buf_bcnt = 6'd0;
        @(posedge pclk); #1;
        rd_req = 1'b0;
        chk(err == 1 && busy == 0, "reject_at_rd_down", {err, busy}, 2'b10);
        repeat (6) @(negedge pclk);

        // Reset in the middle of a stream
        apply_reset();
        do_req(4'd6, 7'd2, 6'd0, 1'b0, 0);
        lim = 0;
        while (bytes_done < 10 && lim < 200) begin @(negedge pclk); #1; lim++; end
        chk(bytes_done >= 10, "abort_reached_byte10", bytes_done, 10);
        rst_n = 1'b0;
        #1;
        chk(udp_de == 0 && udp_last == 0 && udp_data == 0, "abort_udp_zero", {udp_de, udp_last, udp_data}, 0);
        chk(busy == 0 && rd_down == 0 && b_cea == 0, "abort_ctrl_zero", {busy, rd_down, b_cea}, 0);
        xfer_active = 0; exp_bytes.delete(); exp_addr.delete();
        repeat (3) @(negedge pclk);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge pclk);
        do_req(4'd7, 7'd1, 6'd9, 1'b1, 0);
        wait_done(500);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            do_req(4'($urandom_range(15)), 7'($urandom_range(10, 1)), 6'($urandom_range(16)),
                   1'($urandom_range(1)), $urandom_range(2));
            wait_done(2000);
        end

`ifdef DPB_MASTER_RD_CSUM_EN
        do_req(4'd5, 7'd1, 6'd4, 1'b0, 0);
        wait_done(500);
        chk(payload_csum == 16'h451C, "csum_known_vector", payload_csum, 16'h451C);
`endif

        repeat (5) @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
